uart_rx_capture: RTL

- Synthesizable 8N1 UART receiver that decodes the serial stream driven on fpioa[1] (uart0_tx).
- Serves as the receiving end of the SoC UART TX path: bench-side console capture and board-level loopback checking.
- Oversamples the line with a runtime baud divisor and buffers decoded bytes in a small FIFO with a valid/ready output handshake.
- Reports framing errors and FIFO overflow.

---
 rtl/uart_rx_capture.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver with runtime baud divisor and a small
// first-word-fall-through byte FIFO.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rxd           serial line (idle high, asynchronous to clk)
//   baud_div      clk cycles per bit, clamped to a minimum of 4, latched per frame
//   rx_data       FIFO head byte (holds last popped byte while empty)
//   rx_valid      FIFO non-empty
//   rx_ready      consumer ready
//   busy          receiver FSM not idle
//   frame_err     one-cycle pulse when a stop bit samples low
//   overflow      sticky: a byte was dropped because the FIFO was full
//   ovf_clr       clears overflow (a same-cycle new overflow wins)
//
// Handshake: a byte transfers on every cycle where rx_valid && rx_ready.
// rx_data is stable while rx_valid && !rx_ready; rx_valid never drops
// without a transfer except on reset.
module uart_rx_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_meta, rxs, rxs_d;
  logic [2:0]       warm;
  logic [DIV_W-1:0] div_q, cnt;
  logic [2:0]       bidx;
  logic [7:0]       shreg;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]  last_q;
  logic        push, pop, full, push_ok;

  // Two-flop synchronizer plus one history flop for edge detection.
  // warm gates edge detection until the reset value of the synchronizer has
  // been flushed, so a line held low through reset is not taken as a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      warm    <= 3'b000;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // Receiver FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_q     <= DIV_MIN;
      cnt       <= '0;
      bidx      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (warm[2] && rxs_d && !rxs) begin
            state <= START;
            cnt   <= '0;
            div_q <= (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
          end
        end
        START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (cnt == (div_q >> 1) - ONE) begin
            cnt  <= '0;
            bidx <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DATA: begin
          if (cnt == div_q - ONE) begin
            shreg[bidx] <= rxs;
            cnt         <= '0;
            if (bidx == 3'd7) state <= STOP;
            else              bidx  <= bidx + 3'd1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        STOP: begin
          if (cnt == div_q - ONE) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        BRK: begin
          // Wait out a held-low line so it yields a single frame_err.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push happens on the stop-sample edge when the stop bit is good.
  always_comb begin
    push    = (state == STOP) && (cnt == div_q - ONE) && rxs;
    pop     = rx_valid && rx_ready;
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  assign rx_valid = (wr_ptr != rd_ptr);
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : last_q;
  assign busy     = (state != IDLE);

endmodule
